// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer so in_ready becomes a pure register output.
module pipe_stage_reg #(
    parameter int             DW        = 134,
    parameter logic [DW-1:0]  RESET_VAL = '0,
    parameter int             CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    input  logic             stall_cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DW-1:0] main_data;

`ifdef PIPE_SKID_EN

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t        state;
    logic [DW-1:0] skid_data;
    logic          out_valid_q;
    logic          in_ready_q;

    // TWO holds the older item in main_data and the newer one in skid_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_data   <= RESET_VAL;
            skid_data   <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_data   <= in_data;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_data <= in_data;
                    end else if (in_valid) begin
                        skid_data  <= in_data;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (out_ready) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_data  <= skid_data;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`else

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    logic   accept;

    assign out_valid = (state == FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= RESET_VAL;
        end else begin
            if (accept && !flush)
                main_data <= in_data;
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY:   if (in_valid) state <= FULL;
                    FULL:    if (out_ready && !in_valid) state <= EMPTY;
                    default: state <= EMPTY;
                endcase
            end
        end
    end

`endif

    assign out_data = main_data;

    // Stall accounting: clear wins, flush cycles are never counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !flush)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; covers base and PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

    localparam int            DW    = 16;
    localparam int            CNT_W = 4;
    localparam logic [DW-1:0] RV    = 16'hDEAD;

    logic             clk           = 1'b0;
    logic             rst           = 1'b1;
    logic             flush         = 1'b0;
    logic             in_valid      = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data       = '0;
    logic             out_valid;
    logic             out_ready     = 1'b0;
    logic [DW-1:0]    out_data;
    logic             stall_cnt_clr = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;

    pipe_stage_reg #(.DW(DW), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes are stable at negedge and take effect on the next posedge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            chk("no_x", 32'($isunknown({out_valid, in_ready, stall_cnt, out_data})), 32'd0);
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: got %0h want none", out_data);
                    end else begin
                        exp_d = sb.pop_front();
                        chk("sb_data", 32'(out_data), 32'(exp_d));
                    end
                end
                if (in_valid && in_ready)
                    sb.push_back(in_data);
            end
        end
    end

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'(RV));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // reset in the middle of a stalled transfer
        in_valid = 1'b1; in_data = 16'h0011; out_ready = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_cnt",   32'(stall_cnt), 32'd1);
        chk("pre_rst_ready", 32'(in_ready),  32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'(RV));
        chk("mid_rst_cnt",   32'(stall_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        cyc();
        rst = 1'b0;
        cyc();

        // streaming at full throughput, one cycle latency
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = DW'(i);
            cyc();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data",  32'(out_data),  32'(i));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_end_valid", 32'(out_valid), 32'd0);
        chk("stream_cnt",       32'(stall_cnt), 32'd0);

        // backpressure
        in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
        cyc();
        in_data = 16'h005A; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_data", 32'(out_data), 32'h00A5);
        end
        chk("bp_cnt",   32'(stall_cnt), 32'd5);
        chk("bp_ready", 32'(in_ready),  32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
`ifdef PIPE_SKID_EN
        chk("bp_skid_valid", 32'(out_valid), 32'd1);
        chk("bp_skid_data",  32'(out_data),  32'h005A);
`else
        chk("bp_base_valid", 32'(out_valid), 32'd0);
`endif
        cyc();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_cnt_kept",    32'(stall_cnt), 32'd5);

        // flush with a held item and an incoming one
        in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b1;
        cyc();
        chk("fl_load_data", 32'(out_data), 32'h0077);
        in_data = 16'h003C; flush = 1'b1;
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("fl_valid2", 32'(out_valid), 32'd0);

        // flush during a stall does not count
        stall_cnt_clr = 1'b1; in_valid = 1'b1; in_data = 16'h0044; out_ready = 1'b0;
        cyc();
        chk("fl_clr_cnt", 32'(stall_cnt), 32'd0);
        chk("fl_44_data", 32'(out_data),  32'h0044);
        stall_cnt_clr = 1'b0; in_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_stall_cnt",   32'(stall_cnt), 32'd0);
        chk("fl_stall_valid", 32'(out_valid), 32'd0);

        // saturation
        in_valid = 1'b1; in_data = 16'h0099; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_cnt",  32'(stall_cnt), 32'd15);
        chk("sat_data", 32'(out_data),  32'h0099);
        stall_cnt_clr = 1'b1;
        cyc();
        chk("sat_clr", 32'(stall_cnt), 32'd0);
        stall_cnt_clr = 1'b0;
        cyc();
        chk("sat_restart", 32'(stall_cnt), 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("sat_drain_valid", 32'(out_valid), 32'd0);

        // random valid/ready, checked by the scoreboard
        for (int i = 0; i < 4000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_valid",    32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
